// File: rtl/usb_token_rx.sv
// USB token packet receiver.
// Takes a destuffed, NRZI-decoded serial bit stream framed by SOP/EOP pulses.
// Decodes OUT/IN/SOF/SETUP tokens and reports PID-check, CRC5 and length errors.
module usb_token_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_sop,
  input  logic        in_bit_valid,
  input  logic        in_bit,
  input  logic        in_eop,
  output logic        tok_valid,
  output logic [3:0]  tok_pid,
  output logic [6:0]  tok_addr,
  output logic [3:0]  tok_endp,
  output logic [10:0] tok_frame,
  output logic        err_valid,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    IDLE,
    PID,
    FIELD,
    WAIT_EOP,
    DROP
  } state_t;

  localparam logic [4:0] CRC_INIT     = 5'b11111;
  localparam logic [4:0] CRC_RESIDUAL = 5'b01100;
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_PID      = 2'b01;
  localparam logic [1:0] ERR_CRC      = 2'b10;
  localparam logic [1:0] ERR_LEN      = 2'b11;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  pid_sh_q, pid_sh_d;
  logic [10:0] field_sh_q, field_sh_d;
  logic [4:0]  crc_q, crc_d;
  logic [1:0]  pend_q, pend_d;
  logic        tok_valid_q, tok_valid_d;
  logic        err_valid_q, err_valid_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [3:0]  tok_pid_q, tok_pid_d;
  logic [10:0] tok_field_q, tok_field_d;

  logic [7:0]  pid_byte;
  logic [4:0]  crc_next;

  // Bits arrive LSB-first, so new bits enter at the top of the shift registers.
  assign pid_byte = {in_bit, pid_sh_q[7:1]};
  assign crc_next = {crc_q[3], crc_q[2], crc_q[1] ^ crc_q[4] ^ in_bit,
                     crc_q[0], crc_q[4] ^ in_bit};

  // State and datapath registers, with synchronous reset to the idle condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pid_sh_q    <= '0;
      field_sh_q  <= '0;
      crc_q       <= CRC_INIT;
      pend_q      <= ERR_NONE;
      tok_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      tok_pid_q   <= '0;
      tok_field_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pid_sh_q    <= pid_sh_d;
      field_sh_q  <= field_sh_d;
      crc_q       <= crc_d;
      pend_q      <= pend_d;
      tok_valid_q <= tok_valid_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      tok_pid_q   <= tok_pid_d;
      tok_field_q <= tok_field_d;
    end
  end

  // Next state: SOP restarts; otherwise consume any bit first, then act on EOP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pid_sh_d    = pid_sh_q;
    field_sh_d  = field_sh_q;
    crc_d       = crc_q;
    pend_d      = pend_q;
    tok_valid_d = 1'b0;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    tok_pid_d   = tok_pid_q;
    tok_field_d = tok_field_q;

    if (in_sop) begin
      state_d = PID;
      cnt_d   = '0;
      pend_d  = ERR_NONE;
      crc_d   = CRC_INIT;
    end else begin
      case (state_q)
        PID: begin
          if (in_bit_valid) begin
            pid_sh_d = pid_byte;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d = '0;
              if (pid_byte[7:4] != ~pid_byte[3:0]) begin
                state_d = DROP;
                pend_d  = ERR_PID;
              end else if (pid_byte[1:0] == 2'b01) begin
                // OUT, IN, SOF and SETUP are exactly the PIDs ending in 01.
                state_d = FIELD;
                crc_d   = CRC_INIT;
              end else begin
                state_d = DROP;
              end
            end
          end
        end
        FIELD: begin
          if (in_bit_valid) begin
            if (cnt_q < 5'd11) begin
              field_sh_d = {in_bit, field_sh_q[10:1]};
            end
            crc_d = crc_next;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd15) begin
              state_d = WAIT_EOP;
              if (crc_next != CRC_RESIDUAL) begin
                pend_d = ERR_CRC;
              end
            end
          end
        end
        WAIT_EOP: begin
          if (in_bit_valid) begin
            pend_d = ERR_LEN;
          end
        end
        default: begin
        end
      endcase

      if (in_eop) begin
        case (state_d)
          PID, FIELD: begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_LEN;
          end
          WAIT_EOP: begin
            if (pend_d != ERR_NONE) begin
              err_valid_d = 1'b1;
              err_code_d  = pend_d;
            end else begin
              tok_valid_d = 1'b1;
              tok_pid_d   = pid_sh_d[3:0];
              tok_field_d = field_sh_d;
            end
          end
          DROP: begin
            if (pend_d != ERR_NONE) begin
              err_valid_d = 1'b1;
              err_code_d  = pend_d;
            end
          end
          default: begin
          end
        endcase
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = ERR_NONE;
      end
    end
  end

  assign tok_valid = tok_valid_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign tok_pid   = tok_pid_q;
  assign tok_addr  = tok_field_q[6:0];
  assign tok_endp  = tok_field_q[10:7];
  assign tok_frame = tok_field_q;

endmodule

// File: tb/tb_usb_token_rx.sv
// Testbench for usb_token_rx: directed packets plus randomized token traffic,
// each packet outcome predicted by a packet-level reference model.
module tb_usb_token_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_sop;
  logic        in_bit_valid;
  logic        in_bit;
  logic        in_eop;
  logic        tok_valid;
  logic [3:0]  tok_pid;
  logic [6:0]  tok_addr;
  logic [3:0]  tok_endp;
  logic [10:0] tok_frame;
  logic        err_valid;
  logic [1:0]  err_code;

  int testsRun = 0;
  int testsFailed = 0;
  int earlyPulses = 0;

  bit          pktBits[$];
  int          expKind;
  logic [1:0]  expCode;
  logic [3:0]  expPid;
  logic [10:0] expField;
  logic [3:0]  heldPid = '0;
  logic [10:0] heldField = '0;

  usb_token_rx dut (
    .clk          (clk),
    .rst          (rst),
    .in_sop       (in_sop),
    .in_bit_valid (in_bit_valid),
    .in_bit       (in_bit),
    .in_eop       (in_eop),
    .tok_valid    (tok_valid),
    .tok_pid      (tok_pid),
    .tok_addr     (tok_addr),
    .tok_endp     (tok_endp),
    .tok_frame    (tok_frame),
    .err_valid    (err_valid),
    .err_code     (err_code)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Counts one comparison and reports it when the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives one clock cycle of inputs, then returns just after the rising edge.
  task automatic applyStimulus(input logic sop, input logic bv, input logic b, input logic eop);
    in_sop       = sop;
    in_bit_valid = bv;
    in_bit       = b;
    in_eop       = eop;
    @(posedge clk);
    #1;
    in_sop       = 1'b0;
    in_bit_valid = 1'b0;
    in_bit       = 1'b0;
    in_eop       = 1'b0;
  endtask

  // Any pulse seen before a packet's EOP has been applied is unexpected.
  task automatic noteEarly();
    if (tok_valid || err_valid) earlyPulses++;
  endtask

  // USB token CRC5 as a transmitter computes it: remainder of x^5+x^2+1, inverted.
  function automatic logic [4:0] usbCrc5(input logic [10:0] f);
    logic [4:0] r;
    logic       fb;
    r = 5'b11111;
    for (int i = 0; i < 11; i++) begin
      fb = r[4] ^ f[i];
      r  = {r[3:0], 1'b0};
      if (fb) r = r ^ 5'b00101;
    end
    return ~r;
  endfunction

  task automatic pushBits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) pktBits.push_back(v[i]);
  endtask

  // Appends PID byte, 11-bit field and its CRC5 (sent MSB first).
  task automatic pushToken(input logic [3:0] pid, input logic [10:0] field);
    logic [4:0] crc;
    crc = usbCrc5(field);
    pushBits({24'd0, ~pid, pid}, 8);
    pushBits({21'd0, field}, 11);
    for (int k = 4; k >= 0; k--) pktBits.push_back(crc[k]);
  endtask

  // Packet-level reference: decides the outcome from the whole bit list.
  task automatic modelPacket();
    int          n;
    logic [7:0]  pid;
    logic [10:0] field;
    logic [4:0]  rxCrc;
    n       = pktBits.size();
    expKind = 0;
    expCode = 2'b00;
    if (n < 8) begin
      expKind = 2;
      expCode = 2'b11;
      return;
    end
    for (int i = 0; i < 8; i++) pid[i] = pktBits[i];
    if (pid[7:4] != ~pid[3:0]) begin
      expKind = 2;
      expCode = 2'b01;
    end else if (!(pid[3:0] inside {4'b0001, 4'b1001, 4'b0101, 4'b1101})) begin
      expKind = 0;
    end else if (n != 24) begin
      expKind = 2;
      expCode = 2'b11;
    end else begin
      for (int i = 0; i < 11; i++) field[i] = pktBits[8 + i];
      for (int k = 0; k < 5; k++) rxCrc[4 - k] = pktBits[19 + k];
      if (rxCrc != usbCrc5(field)) begin
        expKind = 2;
        expCode = 2'b10;
      end else begin
        expKind  = 1;
        expPid   = pid[3:0];
        expField = field;
      end
    end
  endtask

  // Compares the cycle after EOP against the model, then checks pulses are one cycle.
  task automatic checkEnd(input string name);
    checkOutput({name, "_early"}, 32'(earlyPulses), 32'd0);
    checkOutput({name, "_tok_valid"}, 32'(tok_valid), 32'(expKind == 1));
    checkOutput({name, "_err_valid"}, 32'(err_valid), 32'(expKind == 2));
    if (expKind == 2) checkOutput({name, "_err_code"}, 32'(err_code), 32'(expCode));
    if (expKind == 1) begin
      heldPid   = expPid;
      heldField = expField;
    end
    checkOutput({name, "_pid"}, 32'(tok_pid), 32'(heldPid));
    checkOutput({name, "_addr"}, 32'(tok_addr), 32'(heldField[6:0]));
    checkOutput({name, "_endp"}, 32'(tok_endp), 32'(heldField[10:7]));
    checkOutput({name, "_frame"}, 32'(tok_frame), 32'(heldField));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput({name, "_pulse_len"}, 32'(tok_valid | err_valid), 32'd0);
  endtask

  // Sends pktBits framed by SOP/EOP, optionally with idle gaps and EOP on the last bit.
  task automatic sendPacket(input string name, input bit coincide, input int gapPct);
    int n;
    n = pktBits.size();
    modelPacket();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    noteEarly();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < gapPct) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        noteEarly();
      end
      if (i == n - 1 && coincide) begin
        applyStimulus(1'b0, 1'b1, pktBits[i], 1'b1);
      end else begin
        applyStimulus(1'b0, 1'b1, pktBits[i], 1'b0);
        noteEarly();
      end
    end
    if (!(coincide && n > 0)) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkEnd(name);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_tok_valid"}, 32'(tok_valid), 32'd0);
    checkOutput({name, "_err_valid"}, 32'(err_valid), 32'd0);
    checkOutput({name, "_err_code"}, 32'(err_code), 32'd0);
    checkOutput({name, "_pid"}, 32'(tok_pid), 32'd0);
    checkOutput({name, "_addr"}, 32'(tok_addr), 32'd0);
    checkOutput({name, "_endp"}, 32'(tok_endp), 32'd0);
    checkOutput({name, "_frame"}, 32'(tok_frame), 32'd0);
  endtask

  // Builds one random packet of a randomly chosen class into pktBits.
  task automatic genRandom();
    int          kind;
    logic [3:0]  lo;
    logic [3:0]  tokPids [4];
    logic [10:0] field;
    int          len;
    tokPids = '{4'b0001, 4'b1001, 4'b0101, 4'b1101};
    pktBits.delete();
    kind  = $urandom_range(0, 6);
    field = 11'($urandom_range(0, 2047));
    lo    = tokPids[$urandom_range(0, 3)];
    case (kind)
      0, 1: pushToken(lo, field);
      2: begin
        pushToken(lo, field);
        len = 19 + $urandom_range(0, 4);
        pktBits[len] = ~pktBits[len];
      end
      3: begin
        lo = 4'($urandom_range(0, 15));
        pushBits({24'd0, ~lo ^ 4'($urandom_range(1, 15)), lo}, 8);
        pushBits($urandom, $urandom_range(0, 20));
      end
      4: begin
        lo = 4'($urandom_range(0, 15));
        while (lo[1:0] == 2'b01) lo = 4'($urandom_range(0, 15));
        pushBits({24'd0, ~lo, lo}, 8);
        pushBits($urandom, $urandom_range(0, 20));
      end
      5: begin
        pushToken(lo, field);
        len = $urandom_range(0, 23);
        while (pktBits.size() > len) void'(pktBits.pop_back());
      end
      default: begin
        pushToken(lo, field);
        pushBits($urandom, $urandom_range(1, 3));
      end
    endcase
  endtask

  // Main sequence: reset, directed packets, abort and reset cases, random traffic.
  initial begin
    rst          = 1'b1;
    in_sop       = 1'b0;
    in_bit_valid = 1'b0;
    in_bit       = 1'b0;
    in_eop       = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkAllZero("reset");

    pktBits.delete(); pushBits(8'h2D, 8); pushBits(8'h00, 8); pushBits(8'h10, 8);
    earlyPulses = 0; sendPacket("setup", 1'b0, 0);
    checkOutput("setup_pid_const", 32'(tok_pid), 32'h0D);

    pktBits.delete(); pushBits(8'h69, 8); pushBits(8'h00, 8); pushBits(8'h10, 8);
    earlyPulses = 0; sendPacket("in_tok", 1'b0, 0);
    checkOutput("in_pid_const", 32'(tok_pid), 32'h09);

    pktBits.delete(); pushBits(8'h69, 8); pushBits(8'h00, 8); pushBits(8'h11, 8);
    earlyPulses = 0; sendPacket("in_badcrc", 1'b0, 0);

    pktBits.delete(); pushBits(8'h2C, 8);
    earlyPulses = 0; sendPacket("pid_check", 1'b0, 0);

    pktBits.delete(); pushBits(8'hD2, 8);
    earlyPulses = 0; sendPacket("ack_drop", 1'b1, 0);

    pktBits.delete(); pushBits(8'hE1, 8); pushBits(8'h00, 8); pushBits(8'h10, 4);
    earlyPulses = 0; sendPacket("out_short", 1'b0, 0);

    pktBits.delete(); pushBits(8'hE1, 8); pushBits(8'h00, 8); pushBits(8'h10, 8); pushBits(1, 1);
    earlyPulses = 0; sendPacket("out_long", 1'b0, 0);

    // Aborted packet: SOP arrives while the first packet is mid-field.
    pktBits.delete(); pushBits(8'h69, 8); pushBits(8'h00, 8); pushBits(8'h10, 3);
    earlyPulses = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    noteEarly();
    foreach (pktBits[i]) begin
      applyStimulus(1'b0, 1'b1, pktBits[i], 1'b0);
      noteEarly();
    end
    pktBits.delete(); pushBits(8'h69, 8); pushBits(8'h00, 8); pushBits(8'h10, 8);
    sendPacket("abort_restart", 1'b0, 0);

    // Reset for one cycle mid-field, then EOP: nothing may come out.
    pktBits.delete(); pushBits(8'hE1, 8); pushBits(8'h5A, 5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    foreach (pktBits[i]) applyStimulus(1'b0, 1'b1, pktBits[i], 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkAllZero("mid_rst_eop");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkAllZero("mid_rst_after");
    heldPid   = '0;
    heldField = '0;
    pktBits.delete(); pushToken(4'b0101, 11'h5A3);
    earlyPulses = 0; sendPacket("post_rst_sof", 1'b0, 0);

    for (int p = 0; p < 80; p++) begin
      genRandom();
      earlyPulses = 0;
      sendPacket("rand", 1'($urandom_range(0, 1)), 25);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
